// File: rtl/montgomery_mul_serial.sv
// Radix-2 bit-serial Montgomery multiplier: result = a * b * 2^-WIDTH mod m.
// One LOOP iteration per bit of a, then a single conditional final subtraction.
module montgomery_mul_serial #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOOP = 2'd1,
        S_SUB  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH+1:0]   c_q;
    logic [CW-1:0]      i_q;
    logic               done_q;
    logic               busy_q;

    logic               bit_a;
    logic               q_bit;
    logic [WIDTH+1:0]   sum;
    logic [WIDTH+1:0]   c_d;
    logic               c_ge_m;
    logic [WIDTH-1:0]   result_d;

    // C stays below 2M, so the un-shifted sum is below 4M and fits WIDTH+2 bits.
    always_comb begin
        bit_a    = a_q[0];
        q_bit    = c_q[0] ^ (bit_a & b_q[0]);
        sum      = c_q
                 + (bit_a ? {2'b00, b_q} : {(WIDTH+2){1'b0}})
                 + (q_bit ? {2'b00, m_q} : {(WIDTH+2){1'b0}});
        c_d      = sum >> 1;
        c_ge_m   = (c_q >= {2'b00, m_q});
        // Low WIDTH bits of the difference are exact, so subtract at result width.
        result_d = c_ge_m ? (c_q[WIDTH-1:0] - m_q) : c_q[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            c_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        m_q     <= in_m;
                        c_q     <= '0;
                        i_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOOP;
                    end
                end
                S_LOOP: begin
                    c_q <= c_d;
                    a_q <= a_q >> 1;
                    i_q <= i_q + CW'(1);
                    if (i_q == CW'(WIDTH - 1)) begin
                        state_q <= S_SUB;
                    end
                end
                S_SUB: begin
                    result_q <= result_d;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule
